oaram_packer: RTL and testbench

Sparse output encoder between the post-processing unit and the output activation RAM. It accepts the dense stream of quantized 8-bit activations that the PPU drains from the accumulator buffer. Each nonzero value is encoded as a (value, zero-run index) entry, and entries are packed VALUES_PER_WORD to a word and written to the OARAM at sequential addresses. The encoded tile is the compressed input activation set for the next layer's fusion units.

---
 rtl/bitfuscnn_pkg.sv | 26 ++
 rtl/zero_run_encoder.sv | 53 +++++
 rtl/oaram_packer.sv | 201 ++++++++++++++++++++
 tb/tb_oaram_packer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitfuscnn_pkg.sv
// bitfuscnn_pkg
// Shared types and helpers for the OARAM sparse output packer.
//   packer_state_t : packer FSM states (IDLE/RUN/DRAIN)
//   oaram_entry_t  : one encoded (value, zero-run index) entry
//   max_run()      : largest zero run representable in an index field
// Build option: none in this file (see oaram_packer for OARAM_PACKER_STATS_EN).
package bitfuscnn_pkg;

  localparam int OARAM_INDEX_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } packer_state_t;

  typedef struct packed {
    logic [7:0]                   value;
    logic [OARAM_INDEX_WIDTH-1:0] index;
  } oaram_entry_t;

  function automatic int max_run(input int index_width);
    return (1 << index_width) - 1;
  endfunction

endpackage

// File: rtl/zero_run_encoder.sv
// zero_run_encoder
// Turns a dense stream of accepted 8-bit activations into (value, run)
// entries. Nonzero values emit immediately with the preceding zero run; a
// run that reaches MAX_RUN emits a (0, MAX_RUN) run-limit entry. Trailing
// zeros never emit; the run is simply discarded when the next tile starts.
// Ports:
//   clk, reset    : clock, async active-high reset
//   clear         : clears the run counter (tile start)
//   accept        : in_value is transferred this cycle
//   in_value      : activation
//   entry_valid   : an entry is produced this cycle (combinational)
//   entry_value   : entry value
//   entry_index   : entry zero-run index
module zero_run_encoder
  import bitfuscnn_pkg::*;
#(
  parameter int INDEX_WIDTH = OARAM_INDEX_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   accept,
  input  logic [7:0]             in_value,
  output logic                   entry_valid,
  output logic [7:0]             entry_value,
  output logic [INDEX_WIDTH-1:0] entry_index
);

  localparam logic [INDEX_WIDTH-1:0] MAX_RUN = INDEX_WIDTH'(max_run(INDEX_WIDTH));

  logic [INDEX_WIDTH-1:0] run;
  logic                   nonzero;
  logic                   run_full;

  assign nonzero     = |in_value;
  assign run_full    = (run == MAX_RUN);
  assign entry_valid = accept && (nonzero || run_full);
  // A run-limit entry carries value 0 (in_value is zero) and index MAX_RUN (run).
  assign entry_value = in_value;
  assign entry_index = run;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run <= '0;
    end else if (clear) begin
      run <= '0;
    end else if (accept) begin
      if (entry_valid) run <= '0;
      else             run <= run + INDEX_WIDTH'(1);
    end
  end

endmodule

// File: rtl/oaram_packer.sv
// oaram_packer
// Sparse output encoder: packs (value, zero-run) entries VALUES_PER_WORD to
// an OARAM word and writes them to sequential addresses from base_address.
// Ports:
//   clk, reset              : clock, async active-high reset
//   start, base_address     : begin a tile (IDLE only), first write address
//   in_valid/in_ready       : input handshake; in_value, in_last
//   oaram_value             : packed values, slot k at [8k+7:8k]
//   oaram_indices_value     : packed run indices, slot k at [IW*k+IW-1:IW*k]
//   oaram_address           : write address
//   oaram_write_enable      : one-cycle write strobe
//   done                    : one-cycle end-of-tile pulse
//   word_count              : words written this tile
//   overflow                : sticky address-wrap flag
// Build option OARAM_PACKER_STATS_EN adds saturating 16-bit nonzero_count and
// placeholder_count outputs, both cleared on start.
//
// state | meaning
// IDLE  | waiting for start; in_ready low
// RUN   | accepting activations every cycle
// DRAIN | one cycle after in_last: done high, final padded write if any
module oaram_packer
  import bitfuscnn_pkg::*;
#(
  parameter int RAM_WIDTH       = 10,
  parameter int INDEX_WIDTH     = OARAM_INDEX_WIDTH,
  parameter int VALUES_PER_WORD = 3
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [RAM_WIDTH-1:0]                 base_address,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [7:0]                           in_value,
  input  logic                                 in_last,
  output logic [8*VALUES_PER_WORD-1:0]         oaram_value,
  output logic [INDEX_WIDTH*VALUES_PER_WORD-1:0] oaram_indices_value,
  output logic [RAM_WIDTH-1:0]                 oaram_address,
  output logic                                 oaram_write_enable,
  output logic                                 done,
  output logic [RAM_WIDTH:0]                   word_count,
  output logic                                 overflow
`ifdef OARAM_PACKER_STATS_EN
  ,
  output logic [15:0]                          nonzero_count,
  output logic [15:0]                          placeholder_count
`endif
);

  localparam int SCW = $clog2(VALUES_PER_WORD + 1);

  packer_state_t state, state_next;

  logic                   accept;
  logic                   start_tile;
  logic                   entry_valid;
  logic [7:0]             entry_value;
  logic [INDEX_WIDTH-1:0] entry_index;

  logic [SCW-1:0]         slot_count;
  logic [7:0]             slot_value [VALUES_PER_WORD];
  logic [INDEX_WIDTH-1:0] slot_index [VALUES_PER_WORD];
  logic [RAM_WIDTH-1:0]   addr_q;

  logic [8*VALUES_PER_WORD-1:0]           word_value;
  logic [INDEX_WIDTH*VALUES_PER_WORD-1:0] word_index;
  logic                                   word_full;
  logic                                   flush;
  logic                                   write_now;

  assign accept     = in_valid && in_ready;
  assign start_tile = start && (state == IDLE);

  zero_run_encoder #(
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_encoder (
    .clk         (clk),
    .reset       (reset),
    .clear       (start_tile),
    .accept      (accept),
    .in_value    (in_value),
    .entry_valid (entry_valid),
    .entry_value (entry_value),
    .entry_index (entry_index)
  );

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (accept && in_last) state_next = DRAIN;
      DRAIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready = (state == RUN);
    done     = (state == DRAIN);
  end

  // Word image as it will be written this cycle: stored slots, the new entry
  // in the next free slot, and (0,0) padding beyond.
  always_comb begin
    word_value = '0;
    word_index = '0;
    for (int k = 0; k < VALUES_PER_WORD; k++) begin
      if (SCW'(k) < slot_count) begin
        word_value[8*k +: 8]                   = slot_value[k];
        word_index[INDEX_WIDTH*k +: INDEX_WIDTH] = slot_index[k];
      end else if (entry_valid && (SCW'(k) == slot_count)) begin
        word_value[8*k +: 8]                   = entry_value;
        word_index[INDEX_WIDTH*k +: INDEX_WIDTH] = entry_index;
      end
    end
  end

  assign word_full = entry_valid && (slot_count == SCW'(VALUES_PER_WORD - 1));
  assign flush     = accept && in_last && ((slot_count != '0) || entry_valid);
  assign write_now = word_full || flush;

  // Slot storage needs no reset: slot_count masks anything stale.
  always_ff @(posedge clk) begin
    if (entry_valid && !write_now) begin
      for (int k = 0; k < VALUES_PER_WORD; k++) begin
        if (SCW'(k) == slot_count) begin
          slot_value[k] <= entry_value;
          slot_index[k] <= entry_index;
        end
      end
    end
  end

  // The address register is the write address; it advances in the write
  // cycle so the next address is visible one cycle later, which keeps
  // single-slot words writing back to back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oaram_write_enable  <= 1'b0;
      oaram_value         <= '0;
      oaram_indices_value <= '0;
      addr_q              <= '0;
      slot_count          <= '0;
      word_count          <= '0;
      overflow            <= 1'b0;
    end else begin
      oaram_write_enable <= write_now;
      if (write_now) begin
        oaram_value         <= word_value;
        oaram_indices_value <= word_index;
      end
      if (start_tile) begin
        addr_q     <= base_address;
        slot_count <= '0;
        word_count <= '0;
        overflow   <= 1'b0;
      end else begin
        if (write_now) begin
          slot_count <= '0;
          word_count <= word_count + (RAM_WIDTH+1)'(1);
        end else if (entry_valid) begin
          slot_count <= slot_count + SCW'(1);
        end
        if (oaram_write_enable) begin
          addr_q <= addr_q + RAM_WIDTH'(1);
          if (&addr_q) overflow <= 1'b1;
        end
      end
    end
  end

  assign oaram_address = addr_q;

`ifdef OARAM_PACKER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nonzero_count     <= '0;
      placeholder_count <= '0;
    end else if (start_tile) begin
      nonzero_count     <= '0;
      placeholder_count <= '0;
    end else if (entry_valid) begin
      if (entry_value != 8'd0) begin
        if (nonzero_count != 16'hFFFF) nonzero_count <= nonzero_count + 16'd1;
      end else begin
        if (placeholder_count != 16'hFFFF) placeholder_count <= placeholder_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_oaram_packer.sv
module tb_oaram_packer;

  localparam int RW   = 10;
  localparam int IW   = 4;
  localparam int VPW  = 3;
  localparam int MAXR = (1 << IW) - 1;
  localparam int ASPACE = 1 << RW;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [RW-1:0]   base_address;
  logic            in_valid;
  logic            in_ready;
  logic [7:0]      in_value;
  logic            in_last;
  logic [8*VPW-1:0]  oaram_value;
  logic [IW*VPW-1:0] oaram_indices_value;
  logic [RW-1:0]   oaram_address;
  logic            oaram_write_enable;
  logic            done;
  logic [RW:0]     word_count;
  logic            overflow;
`ifdef OARAM_PACKER_STATS_EN
  logic [15:0]     nonzero_count;
  logic [15:0]     placeholder_count;
`endif

  oaram_packer dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .base_address        (base_address),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_value            (in_value),
    .in_last             (in_last),
    .oaram_value         (oaram_value),
    .oaram_indices_value (oaram_indices_value),
    .oaram_address       (oaram_address),
    .oaram_write_enable  (oaram_write_enable),
    .done                (done),
    .word_count          (word_count),
    .overflow            (overflow)
`ifdef OARAM_PACKER_STATS_EN
    ,
    .nonzero_count       (nonzero_count),
    .placeholder_count   (placeholder_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // observed writes and done pulses
  int obs_addr[$], obs_val[$], obs_idx[$], obs_cyc[$], done_cyc[$];

  always @(negedge clk) begin
    if (oaram_write_enable === 1'b1) begin
      obs_addr.push_back(int'(oaram_address));
      obs_val.push_back(int'(oaram_value));
      obs_idx.push_back(int'(oaram_indices_value));
      obs_cyc.push_back(cyc);
    end
    if (done === 1'b1) done_cyc.push_back(cyc);
  end

  // stimulus and reference model results
  int stim[256];
  int stim_n;
  int acc_cyc[256];
  int exp_addr[$], exp_val[$], exp_idx[$], exp_src[$];
  int exp_words;
  int exp_nz, exp_ph;
  bit exp_ovf;

  task automatic clear_obs();
    obs_addr.delete(); obs_val.delete(); obs_idx.delete(); obs_cyc.delete();
    done_cyc.delete();
  endtask

  // Reference: list the entries the encoding rules produce, then cut the
  // list into words of VPW entries padded with zeros.
  task automatic build_model(input int base);
    int ev[$], ei[$], es[$];
    int run, v, x, src, e;
    exp_addr.delete(); exp_val.delete(); exp_idx.delete(); exp_src.delete();
    run = 0; exp_nz = 0; exp_ph = 0;
    for (int i = 0; i < stim_n; i++) begin
      if (stim[i] != 0) begin
        ev.push_back(stim[i]); ei.push_back(run); es.push_back(i); run = 0; exp_nz++;
      end else if (run == MAXR) begin
        ev.push_back(0); ei.push_back(MAXR); es.push_back(i); run = 0; exp_ph++;
      end else begin
        run++;
      end
    end
    exp_words = (ev.size() + VPW - 1) / VPW;
    for (int w = 0; w < exp_words; w++) begin
      v = 0; x = 0; src = stim_n - 1;
      for (int k = 0; k < VPW; k++) begin
        e = w * VPW + k;
        if (e < ev.size()) begin
          v |= ev[e] << (8 * k);
          x |= ei[e] << (IW * k);
          if (k == VPW - 1) src = es[e];
        end
      end
      exp_addr.push_back((base + w) % ASPACE);
      exp_val.push_back(v);
      exp_idx.push_back(x);
      exp_src.push_back(src);
    end
    exp_ovf = (base + exp_words) >= ASPACE;
  endtask

  task automatic drive_tile(input int base, input int ign_at, input int ign_base, input int gap_pct);
    int i, guard;
    bit v;
    @(posedge clk); #1;
    start = 1'b1; base_address = RW'(base);
    @(posedge clk); #1;
    start = 1'b0; base_address = RW'($urandom);
    i = 0; guard = 0;
    while (i < stim_n && guard < 4000) begin
      v = ($urandom_range(0, 99) >= gap_pct);
      in_valid = v; in_value = 8'(stim[i]); in_last = (i == stim_n - 1);
      if (i == ign_at) begin start = 1'b1; base_address = RW'(ign_base); end
      @(negedge clk);
      if (v) begin
        n_checks++;
        if (in_ready !== 1'b1) begin
          n_fails++;
          $display("FAIL in_ready during RUN: got %b expected 1", in_ready);
        end
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (v) begin acc_cyc[i] = cyc; i++; end
      guard++;
    end
    in_valid = 1'b0; in_last = 1'b0; in_value = '0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_tile(input string name, input int base, input int ign_at, input int ign_base, input int gap_pct);
    int nw;
    build_model(base);
    clear_obs();
    drive_tile(base, ign_at, ign_base, gap_pct);
    n_checks++;
    if (obs_addr.size() != exp_addr.size()) begin
      n_fails++;
      $display("FAIL %s write count: got %0d expected %0d", name, obs_addr.size(), exp_addr.size());
    end
    nw = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int w = 0; w < nw; w++) begin
      n_checks++;
      if (obs_addr[w] != exp_addr[w] || obs_val[w] != exp_val[w] || obs_idx[w] != exp_idx[w]) begin
        n_fails++;
        $display("FAIL %s word %0d: got addr %h val %h idx %h expected addr %h val %h idx %h",
                 name, w, obs_addr[w], obs_val[w], obs_idx[w], exp_addr[w], exp_val[w], exp_idx[w]);
      end
      n_checks++;
      if (obs_cyc[w] != acc_cyc[exp_src[w]]) begin
        n_fails++;
        $display("FAIL %s word %0d timing: got cycle %0d expected %0d", name, w, obs_cyc[w], acc_cyc[exp_src[w]]);
      end
    end
    n_checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != acc_cyc[stim_n - 1]) begin
      n_fails++;
      $display("FAIL %s done: got %0d pulses first at %0d expected one at %0d", name, done_cyc.size(),
               (done_cyc.size() > 0) ? done_cyc[0] : -1, acc_cyc[stim_n - 1]);
    end
    n_checks++;
    if (word_count !== (RW+1)'(exp_words) || overflow !== exp_ovf) begin
      n_fails++;
      $display("FAIL %s counters: got word_count %0d overflow %b expected %0d %b", name, word_count, overflow, exp_words, exp_ovf);
    end
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fails++;
      $display("FAIL %s idle in_ready: got %b expected 0", name, in_ready);
    end
`ifdef OARAM_PACKER_STATS_EN
    n_checks++;
    if (nonzero_count !== 16'(exp_nz) || placeholder_count !== 16'(exp_ph)) begin
      n_fails++;
      $display("FAIL %s stats: got %0d %0d expected %0d %0d", name, nonzero_count, placeholder_count, exp_nz, exp_ph);
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_value = '0; base_address = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({oaram_value, oaram_indices_value, oaram_address, oaram_write_enable, done, word_count, overflow, in_ready} !== '0) begin
      n_fails++;
      $display("FAIL reset outputs: got val %h idx %h addr %h we %b done %b wc %0d ovf %b rdy %b expected all 0",
               oaram_value, oaram_indices_value, oaram_address, oaram_write_enable, done, word_count, overflow, in_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    stim_n = 5; stim[0] = 5; stim[1] = 0; stim[2] = 0; stim[3] = 7; stim[4] = 9;
    test_tile("basic", 'h010, -1, 0, 0);
    n_checks++;
    if (obs_val.size() != 1 || obs_val[0] != 'h090705 || obs_idx[0] != 'h020 || obs_addr[0] != 'h010 || word_count !== 11'd1) begin
      n_fails++;
      $display("FAIL basic literal: got %0d writes word_count %0d expected one write 090705/020 at 010 word_count 1", obs_val.size(), word_count);
    end
  endtask

  task automatic test_long_zero_run();
    stim_n = 18;
    for (int i = 0; i < 17; i++) stim[i] = 0;
    stim[17] = 3;
    test_tile("long_zero", 'h040, -1, 0, 20);
    n_checks++;
    if (obs_val.size() != 1 || obs_val[0] != 'h000300 || obs_idx[0] != 'h01F) begin
      n_fails++;
      $display("FAIL long_zero literal: got %0d writes expected one write 000300/01F", obs_val.size());
    end
  endtask

  task automatic test_address_wrap();
    stim_n = 6;
    for (int i = 0; i < 6; i++) stim[i] = $urandom_range(1, 255);
    test_tile("wrap", 'h3FF, -1, 0, 0);
    n_checks++;
    if (obs_addr.size() != 2 || obs_addr[0] != 'h3FF || obs_addr[1] != 'h000 || overflow !== 1'b1 || word_count !== 11'd2) begin
      n_fails++;
      $display("FAIL wrap literal: got %0d writes overflow %b word_count %0d expected 3FF,000 overflow 1 word_count 2",
               obs_addr.size(), overflow, word_count);
    end
  endtask

  task automatic test_all_zeros();
    stim_n = 4;
    for (int i = 0; i < 4; i++) stim[i] = 0;
    test_tile("all_zeros", 'h200, -1, 0, 0);
    n_checks++;
    if (obs_addr.size() != 0 || word_count !== 11'd0) begin
      n_fails++;
      $display("FAIL all_zeros literal: got %0d writes word_count %0d expected none 0", obs_addr.size(), word_count);
    end
  endtask

  task automatic test_start_in_run();
    stim_n = 12;
    for (int i = 0; i < stim_n; i++) stim[i] = $urandom_range(1, 255);
    test_tile("start_in_run", 'h080, 4, 'h155, 0);
  endtask

  task automatic test_reset_mid_tile();
    clear_obs();
    @(posedge clk); #1;
    start = 1'b1; base_address = RW'('h100);
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1; in_value = 8'd4; in_last = 1'b0;
    @(posedge clk); #1;
    in_value = 8'd0;
    @(posedge clk); #1;
    in_value = 8'd6;
    @(posedge clk); #1;
    in_value = 8'd0;
    @(posedge clk); #2;
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({oaram_value, oaram_indices_value, oaram_address, oaram_write_enable, done, word_count, overflow, in_ready} !== '0
        || obs_addr.size() != 0) begin
      n_fails++;
      $display("FAIL mid_reset outputs: got we %b addr %h wc %0d rdy %b writes %0d expected all 0 and no write",
               oaram_write_enable, oaram_address, word_count, in_ready, obs_addr.size());
    end
    @(posedge clk); #1;
    reset = 1'b0;
    stim_n = 5; stim[0] = 8; stim[1] = 0; stim[2] = 11; stim[3] = 12; stim[4] = 13;
    test_tile("after_reset", 'h020, -1, 0, 0);
  endtask

  task automatic fill_random(input int len, input int zero_pct);
    stim_n = len;
    for (int i = 0; i < len; i++)
      stim[i] = ($urandom_range(0, 99) < zero_pct) ? 0 : $urandom_range(1, 255);
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 4; t++) begin
      fill_random($urandom_range(1, 30), 30);
      test_tile("back_to_back", $urandom_range(0, ASPACE - 1), -1, 0, 0);
    end
  endtask

  task automatic test_random_tiles();
    for (int t = 0; t < 8; t++) begin
      fill_random($urandom_range(1, 60), (t % 2 == 0) ? 50 : 90);
      test_tile("random", (t == 3) ? ASPACE - 5 : $urandom_range(0, ASPACE - 1), -1, 0, 30);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_long_zero_run();
    test_address_wrap();
    test_all_zeros();
    test_start_in_run();
    test_reset_mid_tile();
    test_back_to_back();
    test_random_tiles();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
